// File: rtl/alu_if.sv
// Dispatch and broadcast bundle between the reservation station and the ALU.
// The testbench/RS drives through master; the ALU uses slave.
interface alu_if;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;

    logic        alu_result;
    logic [3:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        alu_result_jump;
    logic [31:0] alu_result_pc;
    logic [31:0] alu_exec_cnt;

    modport master (
        output alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos,
        input  alu_result, alu_result_rob_pos, alu_result_val,
               alu_result_jump, alu_result_pc, alu_exec_cnt
    );

    modport slave (
        input  alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos,
        output alu_result, alu_result_rob_pos, alu_result_val,
               alu_result_jump, alu_result_pc, alu_exec_cnt
    );
endinterface

// File: rtl/alu.sv
// Two-stage RV32I integer ALU: S1 latches the dispatched op, S2 computes and
// registers the CDB broadcast. rdy stalls everything, rollback flushes both stages.
module alu (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rollback,
    alu_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic        s1_valid;
    logic [6:0]  s1_opcode;
    logic [2:0]  s1_funct3;
    logic        s1_funct7;
    logic [31:0] s1_val1;
    logic [31:0] s1_val2;
    logic [31:0] s1_imm;
    logic [31:0] s1_pc;
    logic [3:0]  s1_rob_pos;

    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] arith;
    logic [31:0] pc_plus4;
    logic [31:0] pc_imm;
    logic [31:0] jalr_sum;
    logic        br_taken;
    logic [31:0] res_val;
    logic        res_jump;
    logic [31:0] res_pc;

    always_comb begin
        op2      = (s1_opcode == OPC_OP) ? s1_val2 : s1_imm;
        shamt    = op2[4:0];
        pc_plus4 = s1_pc + 32'd4;
        pc_imm   = s1_pc + s1_imm;
        jalr_sum = s1_val1 + s1_imm;

        arith = '0;
        case (s1_funct3)
            3'b000: begin
                // Only register-register ops subtract; OP-IMM has no SUBI.
                if (s1_opcode == OPC_OP && s1_funct7) arith = s1_val1 - op2;
                else                                  arith = s1_val1 + op2;
            end
            3'b001: arith = s1_val1 << shamt;
            3'b010: arith = {31'd0, $signed(s1_val1) < $signed(op2)};
            3'b011: arith = {31'd0, s1_val1 < op2};
            3'b100: arith = s1_val1 ^ op2;
            3'b101: begin
                if (s1_funct7) arith = $signed(s1_val1) >>> shamt;
                else           arith = s1_val1 >> shamt;
            end
            3'b110: arith = s1_val1 | op2;
            3'b111: arith = s1_val1 & op2;
            default: arith = '0;
        endcase

        br_taken = 1'b0;
        case (s1_funct3)
            3'b000: br_taken = (s1_val1 == s1_val2);
            3'b001: br_taken = (s1_val1 != s1_val2);
            3'b100: br_taken = ($signed(s1_val1) <  $signed(s1_val2));
            3'b101: br_taken = ($signed(s1_val1) >= $signed(s1_val2));
            3'b110: br_taken = (s1_val1 <  s1_val2);
            3'b111: br_taken = (s1_val1 >= s1_val2);
            default: br_taken = 1'b0;
        endcase

        res_val  = '0;
        res_jump = 1'b0;
        res_pc   = pc_plus4;
        case (s1_opcode)
            OPC_OP, OPC_OPIMM: res_val = arith;
            OPC_LUI:           res_val = s1_imm;
            OPC_AUIPC:         res_val = pc_imm;
            OPC_JAL: begin
                res_val  = pc_plus4;
                res_jump = 1'b1;
                res_pc   = pc_imm;
            end
            OPC_JALR: begin
                res_val  = pc_plus4;
                res_jump = 1'b1;
                res_pc   = jalr_sum & ~32'd1;
            end
            OPC_BRANCH: begin
                res_jump = br_taken;
                res_pc   = br_taken ? pc_imm : pc_plus4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid               <= 1'b0;
            s1_opcode              <= '0;
            s1_funct3              <= '0;
            s1_funct7              <= 1'b0;
            s1_val1                <= '0;
            s1_val2                <= '0;
            s1_imm                 <= '0;
            s1_pc                  <= '0;
            s1_rob_pos             <= '0;
            bus.alu_result         <= 1'b0;
            bus.alu_result_rob_pos <= '0;
            bus.alu_result_val     <= '0;
            bus.alu_result_jump    <= 1'b0;
            bus.alu_result_pc      <= '0;
            bus.alu_exec_cnt       <= '0;
        end else if (rdy) begin
            if (rollback) begin
                s1_valid       <= 1'b0;
                bus.alu_result <= 1'b0;
            end else begin
                s1_valid <= bus.alu_en;
                if (bus.alu_en) begin
                    s1_opcode  <= bus.alu_opcode;
                    s1_funct3  <= bus.alu_funct3;
                    s1_funct7  <= bus.alu_funct7;
                    s1_val1    <= bus.alu_val1;
                    s1_val2    <= bus.alu_val2;
                    s1_imm     <= bus.alu_imm;
                    s1_pc      <= bus.alu_pc;
                    s1_rob_pos <= bus.alu_rob_pos;
                end
                // The S2 valid bit is the broadcast strobe itself.
                bus.alu_result <= s1_valid;
                if (s1_valid) begin
                    bus.alu_result_rob_pos <= s1_rob_pos;
                    bus.alu_result_val     <= res_val;
                    bus.alu_result_jump    <= res_jump;
                    bus.alu_result_pc      <= res_pc;
                    bus.alu_exec_cnt       <= bus.alu_exec_cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: pipelined op table, flush, stall and reset priority.
module tb_alu;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;

    alu_if bus ();

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
        logic [31:0] ev;
        logic        ej;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;
    logic [31:0] exp_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] rob,
                       input logic [31:0] ev, input logic ej, input logic [31:0] epc);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.v1 = v1; v.v2 = v2; v.imm = imm;
        v.pc = pc; v.rob = rob; v.ev = ev; v.ej = ej; v.epc = epc;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.alu_en      = 1'b1;
        bus.alu_opcode  = v.opc;
        bus.alu_funct3  = v.f3;
        bus.alu_funct7  = v.f7;
        bus.alu_val1    = v.v1;
        bus.alu_val2    = v.v2;
        bus.alu_imm     = v.imm;
        bus.alu_pc      = v.pc;
        bus.alu_rob_pos = v.rob;
    endtask

    task automatic check_result(input int idx, input vec_t v);
        check($sformatf("valid[%0d]", idx), {31'd0, bus.alu_result}, 32'd1);
        check($sformatf("rob[%0d]", idx),   {28'd0, bus.alu_result_rob_pos}, {28'd0, v.rob});
        check($sformatf("val[%0d]", idx),   bus.alu_result_val, v.ev);
        check($sformatf("jump[%0d]", idx),  {31'd0, bus.alu_result_jump}, {31'd0, v.ej});
        check($sformatf("pc[%0d]", idx),    bus.alu_result_pc, v.epc);
    endtask

    initial begin
        //   opc         f3    f7  v1            v2            imm           pc            rob  exp_val       j  exp_pc
        add(7'b0110011, 3'd0, 0, 32'd5,        32'd7,        32'd0,        32'h40,       3,   32'd12,       0, 32'h44);
        add(7'b0110011, 3'd0, 1, 32'd5,        32'd7,        32'd0,        32'h44,       4,   32'hFFFFFFFE, 0, 32'h48);
        add(7'b0010011, 3'd0, 1, 32'd1,        32'd0,        32'hFFFFFFFF, 32'h48,       5,   32'd0,        0, 32'h4C);
        add(7'b0010011, 3'd5, 1, 32'h80000000, 32'd0,        32'h404,      32'h4C,       6,   32'hF8000000, 0, 32'h50);
        add(7'b0010011, 3'd5, 0, 32'h80000000, 32'd0,        32'h4,        32'h50,       7,   32'h08000000, 0, 32'h54);
        add(7'b0110011, 3'd1, 0, 32'd1,        32'h23,       32'd0,        32'h54,       8,   32'd8,        0, 32'h58);
        add(7'b0110011, 3'd2, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h58,       9,   32'd1,        0, 32'h5C);
        add(7'b0110011, 3'd3, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h5C,       10,  32'd0,        0, 32'h60);
        add(7'b0010011, 3'd4, 0, 32'hF0F0F0F0, 32'd0,        32'hFFFFFFFF, 32'h60,       11,  32'h0F0F0F0F, 0, 32'h64);
        add(7'b0110011, 3'd6, 0, 32'h0F,       32'hF0,       32'd0,        32'h64,       12,  32'hFF,       0, 32'h68);
        add(7'b0110011, 3'd7, 0, 32'hFF,       32'h0F,       32'd0,        32'h68,       13,  32'h0F,       0, 32'h6C);
        add(7'b0110111, 3'd0, 0, 32'd0,        32'd0,        32'h12345000, 32'h6C,       14,  32'h12345000, 0, 32'h70);
        add(7'b0010111, 3'd0, 0, 32'd0,        32'd0,        32'h2000,     32'h1000,     15,  32'h3000,     0, 32'h1004);
        add(7'b1101111, 3'd0, 0, 32'd0,        32'd0,        32'hFFFFFFF0, 32'h300,      0,   32'h304,      1, 32'h2F0);
        add(7'b1100111, 3'd0, 0, 32'h1003,     32'd0,        32'd0,        32'h200,      1,   32'h204,      1, 32'h1002);
        add(7'b1100011, 3'd4, 0, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,      2,   32'd0,        1, 32'h120);
        add(7'b1100011, 3'd6, 0, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,      3,   32'd0,        0, 32'h104);
        add(7'b1100011, 3'd0, 0, 32'd5,        32'd5,        32'h20,       32'h100,      4,   32'd0,        1, 32'h120);
        add(7'b1100011, 3'd1, 0, 32'd5,        32'd5,        32'h20,       32'h100,      5,   32'd0,        0, 32'h104);
        add(7'b1100011, 3'd7, 0, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,      6,   32'd0,        1, 32'h120);
        add(7'b0000000, 3'd0, 0, 32'd7,        32'd9,        32'd3,        32'h500,      7,   32'd0,        0, 32'h504);

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        bus.alu_en = 1'b0; bus.alu_opcode = '0; bus.alu_funct3 = '0; bus.alu_funct7 = 1'b0;
        bus.alu_val1 = '0; bus.alu_val2 = '0; bus.alu_imm = '0; bus.alu_pc = '0; bus.alu_rob_pos = '0;
        tick();
        tick();
        check("rst_valid", {31'd0, bus.alu_result}, 32'd0);
        check("rst_rob",   {28'd0, bus.alu_result_rob_pos}, 32'd0);
        check("rst_val",   bus.alu_result_val, 32'd0);
        check("rst_jump",  {31'd0, bus.alu_result_jump}, 32'd0);
        check("rst_pc",    bus.alu_result_pc, 32'd0);
        check("rst_cnt",   bus.alu_exec_cnt, 32'd0);

        // Back-to-back table, first dispatch in the first cycle after reset.
        rst = 1'b0;
        for (int i = 0; i <= vecs.size(); i++) begin
            if (i < vecs.size()) drive(vecs[i]);
            else                 bus.alu_en = 1'b0;
            tick();
            if (i == 0) check("first_latency", {31'd0, bus.alu_result}, 32'd0);
            else begin
                check_result(i - 1, vecs[i - 1]);
                exp_cnt++;
                check($sformatf("cnt[%0d]", i - 1), bus.alu_exec_cnt, exp_cnt);
            end
        end
        tick();
        check("drain_idle", {31'd0, bus.alu_result}, 32'd0);
        check("drain_cnt",  bus.alu_exec_cnt, exp_cnt);

        // Flush: ops at t and t+1, rollback at t+1.
        drive(vecs[0]);
        tick();
        drive(vecs[1]);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        bus.alu_en = 1'b0;
        check("flush_t2", {31'd0, bus.alu_result}, 32'd0);
        tick();
        check("flush_t3", {31'd0, bus.alu_result}, 32'd0);
        check("flush_cnt", bus.alu_exec_cnt, exp_cnt);

        // Stall with one op in S1; a dispatch offered while stalled must be ignored.
        drive(vecs[14]);
        tick();
        rdy = 1'b0;
        drive(vecs[0]);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall_hold[%0d]", k), {31'd0, bus.alu_result}, 32'd0);
        end
        rdy = 1'b1;
        bus.alu_en = 1'b0;
        tick();
        check_result(100, vecs[14]);
        exp_cnt++;
        check("stall_cnt", bus.alu_exec_cnt, exp_cnt);
        tick();
        check("stall_once", {31'd0, bus.alu_result}, 32'd0);
        check("stall_cnt2", bus.alu_exec_cnt, exp_cnt);

        // Stall while a result is presented: it is re-presented unchanged.
        drive(vecs[3]);
        tick();
        bus.alu_en = 1'b0;
        tick();
        exp_cnt++;
        rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_result(200 + k, vecs[3]);
            check($sformatf("repeat_cnt[%0d]", k), bus.alu_exec_cnt, exp_cnt);
        end
        rdy = 1'b1;
        tick();
        check("repeat_end", {31'd0, bus.alu_result}, 32'd0);

        // Reset wins over a stall and over rollback.
        drive(vecs[0]);
        tick();
        rdy = 1'b0;
        rollback = 1'b1;
        rst = 1'b1;
        tick();
        check("rst_pri_cnt",   bus.alu_exec_cnt, 32'd0);
        check("rst_pri_valid", {31'd0, bus.alu_result}, 32'd0);
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; bus.alu_en = 1'b0;
        tick();
        tick();
        check("rst_pri_s1", {31'd0, bus.alu_result}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset: synchronous, active-high.
REQ-003 rdy  input  1  global enable; low = hold all state.
REQ-004 rollback  input  1  flush both pipeline stages.
REQ-005 alu_en  input  1  dispatch valid from reservation station; one op per cycle, no backpressure.
REQ-006 alu_opcode  input  7  RV32I opcode.
REQ-007 alu_funct3  input  3  funct3.
REQ-008 alu_funct7  input  1  instr[30].
REQ-009 alu_val1, alu_val2  input  32 each  rs1 and rs2 operand values.
REQ-010 alu_imm  input  32  sign-extended immediate.
REQ-011 alu_pc  input  32  instruction PC.
REQ-012 alu_rob_pos  input  4  ROB slot of the op.
REQ-013 alu_result  output  1  broadcast valid, one-cycle pulse per op.
REQ-014 alu_result_rob_pos  output  4  ROB slot of the result.
REQ-015 alu_result_val  output  32  rd value.
REQ-016 alu_result_jump  output  1  control transfer taken.
REQ-017 alu_result_pc  output  32  resolved next PC.
REQ-018 alu_exec_cnt  output  32  count of broadcast results.

Function
REQ-019 Two-stage pipeline, each stage with a valid bit. S1 registers dispatch fields on alu_en. S2 computes and registers the broadcast outputs. alu_result asserts exactly 2 rdy-cycles after alu_en.
REQ-020 Fully pipelined: back-to-back alu_en on N consecutive cycles produces N consecutive alu_result pulses in order.
REQ-021 OP (0110011) computes val1 op val2: ADD/SUB by funct7, SLL, SLT, SLTU, XOR, SRL/SRA by funct7, OR, AND. Shift amount = val2[4:0].
REQ-022 OP-IMM (0010011) computes the same ops with imm as the second operand. funct7 is ignored except for SRLI/SRAI. No SUBI. Shift amount = imm[4:0].
REQ-023 LUI: val = imm. AUIPC: val = pc+imm.
REQ-024 JAL: val = pc+4, jump = 1, pc = pc+imm.
REQ-025 JALR: val = pc+4, jump = 1, pc = (val1+imm) & ~1.
REQ-026 BRANCH covers BEQ/BNE/BLT/BGE/BLTU/BGEU. jump = condition. pc = taken ? pc+imm : pc+4. val = 0.
REQ-027 For non-control ops: jump = 0, pc = pc+4.
REQ-028 Any other opcode: val = 0, jump = 0, pc = pc+4, result still broadcast.
REQ-029 All arithmetic is mod 2^32. SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
REQ-030 alu_result is 0 in any cycle whose S2 valid is 0. Data outputs are don't-care then.
REQ-031 alu_exec_cnt increments by 1 on each cycle alu_result = 1, wrapping at 2^32.
REQ-032 rollback (rdy = 1) clears both valid bits. alu_result is 0 on the next cycle. alu_en in the same cycle is dropped. The counter is not reset.
REQ-033 rdy = 0: all registers and outputs hold, and alu_en is ignored. Any pending alu_result is re-presented unchanged.
REQ-034 rst takes priority over rollback and rdy.

Reset
REQ-035 On rst: S1/S2 valid = 0, alu_result = 0, alu_result_jump = 0, alu_result_rob_pos = 0, alu_result_val = 0, alu_result_pc = 0, alu_exec_cnt = 0.
REQ-036 First dispatch is accepted on the first cycle after rst deasserts.

Verification
REQ-037 Directed ADD then SUB: OP, val1 = 5, val2 = 7, funct7 = 0, rob_pos = 3, then funct7 = 1, rob_pos = 4 on consecutive cycles -> results 12 @ pos 3 and 0xFFFFFFFE @ pos 4 on consecutive cycles, 2 cycles after each dispatch.
REQ-038 Directed ADDI with funct7 = 1, val1 = 1, imm = 0xFFFFFFFF -> val = 0. SRAI with val1 = 0x80000000, imm = 0x404, funct7 = 1 -> 0xF8000000.
REQ-039 Directed branches at pc = 0x100, imm = 0x20:
  - BLT with 0xFFFFFFFF, 1 -> jump = 1, pc = 0x120.
  - BLTU with the same operands -> jump = 0, pc = 0x104.
REQ-040 Directed JALR at pc = 0x200, val1 = 0x1003, imm = 0 -> val = 0x204, jump = 1, pc = 0x1002.
REQ-041 Flush: dispatch ops at cycles t and t+1, rollback at t+1 -> no alu_result at t+2 or t+3, and alu_exec_cnt unchanged.
REQ-042 Stall: rdy = 0 for 3 cycles with one op in S1 -> alu_result appears 1 rdy-high cycle after rdy returns, and exactly once.
